// File: rtl/index_pkg.sv
// Shared widths and lane types for the nibble splitter.
package index_pkg;

    localparam int NIB_W   = 4;
    localparam int NUM_NIB = 4;
    localparam int WORD_W  = NIB_W * NUM_NIB;

    typedef logic [NIB_W-1:0] nibble_t;
    typedef logic [1:0]       nib_idx_t;

    // Extract lane k (least significant lane is 0) from a word.
    function automatic nibble_t get_nib(input logic [WORD_W-1:0] word, input nib_idx_t k);
        get_nib = word[NIB_W*k +: NIB_W];
    endfunction

endpackage

// File: rtl/index_nibble_mux.sv
// 4:1 lane select over a 16-bit word, reusable by per-digit logic.
module nibble_mux
    import index_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  nib_idx_t          sel_i,
    output nibble_t           nib_o
);

    // Pick the lane addressed by sel_i.
    always_comb begin
        nib_o = 4'h0;
        case (sel_i)
            2'd0:    nib_o = word_i[3:0];
            2'd1:    nib_o = word_i[7:4];
            2'd2:    nib_o = word_i[11:8];
            2'd3:    nib_o = word_i[15:12];
            default: nib_o = 4'h0;
        endcase
    end

endmodule

// File: rtl/index.sv
// Nibble splitter: combinational lane outputs, lane select, lowest-nonzero
// lane locator and a registered snapshot of the input word.
module index
    import index_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in,
    input  logic              load,
    input  nib_idx_t          sel,
    output nibble_t           out0,
    output nibble_t           out1,
    output nibble_t           out2,
    output nibble_t           out3,
    output nibble_t           out_sel,
    output logic              any_nz,
    output nib_idx_t          first_nz,
    output logic [WORD_W-1:0] q,
    output logic              q_valid
);

    logic [NUM_NIB-1:0] lane_nz_s;
    logic [WORD_W-1:0]  snap_q;
    logic [WORD_W-1:0]  snap_d;
    logic               valid_q;
    logic               valid_d;

    // Lanes are plain wiring; they never depend on clock, reset or load.
    assign out0 = get_nib(in, 2'd0);
    assign out1 = get_nib(in, 2'd1);
    assign out2 = get_nib(in, 2'd2);
    assign out3 = get_nib(in, 2'd3);

    nibble_mux u_sel_mux (
        .word_i (in),
        .sel_i  (sel),
        .nib_o  (out_sel)
    );

    assign lane_nz_s[0] = |out0;
    assign lane_nz_s[1] = |out1;
    assign lane_nz_s[2] = |out2;
    assign lane_nz_s[3] = |out3;
    assign any_nz       = |lane_nz_s;

    // Priority encode the nonzero lanes, lane 0 first; an all-zero word reports 0.
    always_comb begin
        first_nz = 2'd0;
        if (lane_nz_s[0]) begin
            first_nz = 2'd0;
        end else if (lane_nz_s[1]) begin
            first_nz = 2'd1;
        end else if (lane_nz_s[2]) begin
            first_nz = 2'd2;
        end else if (lane_nz_s[3]) begin
            first_nz = 2'd3;
        end else begin
            first_nz = 2'd0;
        end
    end

    // Next snapshot state: capture on load, otherwise hold.
    always_comb begin
        snap_d  = snap_q;
        valid_d = valid_q;
        if (load) begin
            snap_d  = in;
            valid_d = 1'b1;
        end else begin
            snap_d  = snap_q;
            valid_d = valid_q;
        end
    end

    // Snapshot registers; reset takes priority over a simultaneous load.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q  <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            snap_q  <= snap_d;
            valid_q <= valid_d;
        end
    end

    assign q       = snap_q;
    assign q_valid = valid_q;

endmodule

// File: tb/tb_index.sv
// Directed self-checking bench for the nibble splitter.
module tb_index;

    logic        clk;
    logic        rst;
    logic [15:0] in_s;
    logic        load;
    logic [1:0]  sel;
    logic [3:0]  out0, out1, out2, out3, out_sel;
    logic        any_nz;
    logic [1:0]  first_nz;
    logic [15:0] q;
    logic        q_valid;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    index dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in_s),
        .load     (load),
        .sel      (sel),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .out_sel  (out_sel),
        .any_nz   (any_nz),
        .first_nz (first_nz),
        .q        (q),
        .q_valid  (q_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_lanes(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                               input logic [3:0] e2, input logic [3:0] e3);
        check({tag, " out0"}, {12'h000, out0}, {12'h000, e0});
        check({tag, " out1"}, {12'h000, out1}, {12'h000, e1});
        check({tag, " out2"}, {12'h000, out2}, {12'h000, e2});
        check({tag, " out3"}, {12'h000, out3}, {12'h000, e3});
    endtask

    initial begin
        // Combinational path before any clock edge, with reset asserted.
        rst = 1'b1; load = 1'b0; sel = 2'd2; in_s = 16'hC3FF;
        #1;
        check_lanes("c3ff", 4'hF, 4'hF, 4'h3, 4'hC);
        check("c3ff out_sel",  {12'h000, out_sel},  16'h0003);
        check("c3ff any_nz",   {15'h0000, any_nz},  16'h0001);
        check("c3ff first_nz", {14'h0000, first_nz}, 16'h0000);

        // First reset edge clears the snapshot.
        @(negedge clk);
        check("rst q",       q,                     16'h0000);
        check("rst q_valid", {15'h0000, q_valid},   16'h0000);

        // All-zero word.
        in_s = 16'h0000; #1;
        check_lanes("zero", 4'h0, 4'h0, 4'h0, 4'h0);
        check("zero out_sel",  {12'h000, out_sel},   16'h0000);
        check("zero any_nz",   {15'h0000, any_nz},   16'h0000);
        check("zero first_nz", {14'h0000, first_nz}, 16'h0000);

        // Only the top lane nonzero, sweep the select.
        in_s = 16'h5000; #1;
        check("5000 first_nz", {14'h0000, first_nz}, 16'h0003);
        check("5000 any_nz",   {15'h0000, any_nz},   16'h0001);
        sel = 2'd0; #1; check("5000 sel0", {12'h000, out_sel}, 16'h0000);
        sel = 2'd1; #1; check("5000 sel1", {12'h000, out_sel}, 16'h0000);
        sel = 2'd2; #1; check("5000 sel2", {12'h000, out_sel}, 16'h0000);
        sel = 2'd3; #1; check("5000 sel3", {12'h000, out_sel}, 16'h0005);

        // Middle lanes for the priority encoder.
        in_s = 16'h8100; #1;
        check("8100 first_nz", {14'h0000, first_nz}, 16'h0002);
        in_s = 16'h0A20; #1;
        check("0a20 first_nz", {14'h0000, first_nz}, 16'h0001);
        sel = 2'd1; #1;
        check("0a20 sel1", {12'h000, out_sel}, 16'h0002);

        // Release reset and load 0x1234.
        @(negedge clk);
        rst = 1'b0; load = 1'b1; in_s = 16'h1234; #1;
        check("pre-load q",       q,                   16'h0000);
        check("pre-load q_valid", {15'h0000, q_valid}, 16'h0000);
        @(negedge clk);
        check("load q",       q,                   16'h1234);
        check("load q_valid", {15'h0000, q_valid}, 16'h0001);

        // New word without load: lanes follow, snapshot holds.
        load = 1'b0; in_s = 16'hABCD; #1;
        check_lanes("abcd", 4'hD, 4'hC, 4'hB, 4'hA);
        check("abcd first_nz", {14'h0000, first_nz}, 16'h0000);
        @(negedge clk);
        check("hold q",       q,                   16'h1234);
        check("hold q_valid", {15'h0000, q_valid}, 16'h0001);

        // Reset and load together: reset wins, lanes unaffected.
        rst = 1'b1; load = 1'b1; in_s = 16'hFFFF; #1;
        check("rst+load out3 pre", {12'h000, out3}, 16'h000F);
        @(negedge clk);
        check("rst+load q",        q,                   16'h0000);
        check("rst+load q_valid",  {15'h0000, q_valid}, 16'h0000);
        check("rst+load out3 post", {12'h000, out3},    16'h000F);

        // Back-to-back loads; the last captured value persists.
        rst = 1'b0; load = 1'b1; in_s = 16'h1111;
        @(negedge clk);
        check("b2b first q", q, 16'h1111);
        in_s = 16'h2222;
        @(negedge clk);
        check("b2b second q", q, 16'h2222);
        load = 1'b0; in_s = 16'h3333;
        @(negedge clk);
        check("b2b hold q",       q,                   16'h2222);
        check("b2b hold q_valid", {15'h0000, q_valid}, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
